pipeline_hazard_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage RISC-V CPU. It owns the run/idle/freeze state of the pipeline and resolves load-use stalls and taken-branch flushes. It drives the write enables of PC, IF_ID and ID_EX, and keeps saturating stall, flush and cycle counters for the bench. It sits in CPU beside Control and takes its operands from the IF_ID and ID_EX registers.

---
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: owns IDLE/RUN/FREEZE, resolves load-use stalls
// and taken-branch flushes, and keeps saturating stall/flush/cycle counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic             uses_rs2_i,
    input  logic             id_ex_memread_i,
    input  logic [REG_W-1:0] id_ex_rd_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FREEZE = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic w_rd_nonzero;
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hazard;
    logic w_run_free;
    logic w_active;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = (id_ex_rd_i != '0);
    assign w_rs1_match  = (id_ex_rd_i == rs1_i);
    assign w_rs2_match  = uses_rs2_i && (id_ex_rd_i == rs2_i);
    assign w_hazard     = id_ex_memread_i && w_rd_nonzero && (w_rs1_match || w_rs2_match);

    assign w_run_free   = (r_state == ST_RUN) && !dmem_busy_i;
    assign w_active     = (r_state == ST_RUN) || (r_state == ST_FREEZE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else if (!start_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   r_state <= ST_RUN;
                ST_RUN:    if (dmem_busy_i) r_state <= ST_FREEZE;
                ST_FREEZE: if (!dmem_busy_i) r_state <= ST_RUN;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // A hazard outranks a taken branch: the branch compared a stale operand
    // and will re-resolve once the bubble has let the load complete.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        freeze_o       = !w_run_free;
        if (w_run_free) begin
            if (w_hazard) begin
                id_ex_bubble_o = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
                if_id_flush_o = branch_taken_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (id_ex_bubble_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (if_id_flush_o && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_active && (r_cycle_cnt != '1))       r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign cycle_cnt_o = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: state sequencing, load-use, flush,
// freeze, reset priority and counter saturation (second instance with CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, uses_rs2, memread, branch, busy;
    logic [4:0] rs1, rs2, rd;

    logic        pc_write, if_id_write, flush, bubble, freeze;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt, cycle_cnt;

    logic       s_pc_write, s_if_id_write, s_flush, s_bubble, s_freeze;
    logic [1:0] s_state;
    logic [3:0] s_stall_cnt, s_flush_cnt, s_cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .REG_W(5)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rs1_i(rs1), .rs2_i(rs2), .uses_rs2_i(uses_rs2),
        .id_ex_memread_i(memread), .id_ex_rd_i(rd),
        .branch_taken_i(branch), .dmem_busy_i(busy),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .if_id_flush_o(flush), .id_ex_bubble_o(bubble),
        .freeze_o(freeze), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .cycle_cnt_o(cycle_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .REG_W(5)) u_dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rs1_i(rs1), .rs2_i(rs2), .uses_rs2_i(uses_rs2),
        .id_ex_memread_i(memread), .id_ex_rd_i(rd),
        .branch_taken_i(branch), .dmem_busy_i(busy),
        .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write),
        .if_id_flush_o(s_flush), .id_ex_bubble_o(s_bubble),
        .freeze_o(s_freeze), .state_o(s_state),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .cycle_cnt_o(s_cycle_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; uses_rs2 = 1'b0; memread = 1'b0;
        branch = 1'b0; busy = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        tick(); tick();

        // Reset state and the IDLE -> RUN entry
        rst = 1'b0; start = 1'b1; settle();
        check_eq("rst_state", state, 0);
        check_eq("rst_stall", stall_cnt, 0);
        check_eq("rst_flush", flush_cnt, 0);
        check_eq("rst_cycle", cycle_cnt, 0);
        check_eq("idle_freeze", freeze, 1);
        check_eq("idle_pcw", pc_write, 0);
        tick(); settle();
        check_eq("run_state", state, 1);
        check_eq("run_pcw", pc_write, 1);
        check_eq("run_ifidw", if_id_write, 1);
        check_eq("run_freeze", freeze, 0);
        tick(); tick(); tick(); settle();
        check_eq("cycle3", cycle_cnt, 3);

        // Load-use on rs1
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd9; settle();
        check_eq("lu_pcw", pc_write, 0);
        check_eq("lu_ifidw", if_id_write, 0);
        check_eq("lu_bubble", bubble, 1);
        check_eq("lu_flush", flush, 0);
        check_eq("lu_stall_pre", stall_cnt, 0);
        tick();
        memread = 1'b0; settle();
        check_eq("lu_stall_post", stall_cnt, 1);
        check_eq("lu_released", pc_write, 1);
        // x0 destination and unused rs2 must not stall
        memread = 1'b1; rd = 5'd0; rs1 = 5'd0; settle();
        check_eq("x0_nostall", bubble, 0);
        rd = 5'd7; rs2 = 5'd7; rs1 = 5'd3; uses_rs2 = 1'b0; settle();
        check_eq("rs2_unused", bubble, 0);
        check_eq("rs2_unused_pcw", pc_write, 1);
        uses_rs2 = 1'b1; settle();
        check_eq("rs2_used", bubble, 1);
        memread = 1'b0; settle();
        tick(); settle();
        check_eq("stall_hold", stall_cnt, 1);

        // Taken branch, no hazard
        branch = 1'b1; settle();
        check_eq("br_flush", flush, 1);
        check_eq("br_pcw", pc_write, 1);
        tick();
        branch = 1'b0; settle();
        check_eq("br_flush_cnt", flush_cnt, 1);
        check_eq("br_flush_off", flush, 0);

        // Branch concurrent with load-use on rs2: hazard wins
        branch = 1'b1; memread = 1'b1; rd = 5'd7; rs2 = 5'd7; uses_rs2 = 1'b1; settle();
        check_eq("brhz_flush", flush, 0);
        check_eq("brhz_bubble", bubble, 1);
        tick();
        memread = 1'b0; settle();
        check_eq("brhz_stall", stall_cnt, 2);
        check_eq("brhz_flush_cnt", flush_cnt, 1);
        check_eq("brhz_reflush", flush, 1);
        tick();
        branch = 1'b0; settle();
        check_eq("brhz_flush_cnt2", flush_cnt, 2);
        check_eq("brhz_stall2", stall_cnt, 2);

        // Fresh run, then 3 busy cycles with a concurrent hazard
        rst = 1'b1; tick();
        rst = 1'b0; settle();
        check_eq("rst2_state", state, 0);
        check_eq("rst2_cycle", cycle_cnt, 0);
        check_eq("rst2_flush", flush_cnt, 0);
        tick(); settle();
        check_eq("run2_state", state, 1);
        busy = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5; settle();
        check_eq("fz1_freeze", freeze, 1);
        check_eq("fz1_bubble", bubble, 0);
        check_eq("fz1_pcw", pc_write, 0);
        check_eq("fz1_state", state, 1);
        tick(); settle();
        check_eq("fz2_state", state, 2);
        check_eq("fz2_freeze", freeze, 1);
        check_eq("fz2_bubble", bubble, 0);
        check_eq("fz2_ifidw", if_id_write, 0);
        tick(); settle();
        check_eq("fz3_state", state, 2);
        check_eq("fz3_freeze", freeze, 1);
        tick();
        busy = 1'b0; memread = 1'b0; settle();
        check_eq("fz_cycle", cycle_cnt, 3);
        check_eq("fz_stall", stall_cnt, 0);
        check_eq("fz_exit_freeze", freeze, 1);
        tick(); settle();
        check_eq("fz_back_run", state, 1);
        check_eq("fz_back_freeze", freeze, 0);
        check_eq("fz_cycle4", cycle_cnt, 4);

        // start_i drop while frozen
        busy = 1'b1; tick(); settle();
        check_eq("fz4_state", state, 2);
        start = 1'b0; tick(); settle();
        check_eq("stop_state", state, 0);
        check_eq("stop_cycle", cycle_cnt, 6);
        check_eq("stop_stall", stall_cnt, 0);
        busy = 1'b0; tick(); settle();
        check_eq("idle_cycle_hold", cycle_cnt, 6);

        // Reset mid-stall
        start = 1'b1; tick(); settle();
        check_eq("run3_state", state, 1);
        memread = 1'b1; rd = 5'd4; rs1 = 5'd4; settle();
        check_eq("run3_bubble", bubble, 1);
        rst = 1'b1; tick();
        rst = 1'b0; memread = 1'b0; settle();
        check_eq("rstst_state", state, 0);
        check_eq("rstst_stall", stall_cnt, 0);
        check_eq("rstst_cycle", cycle_cnt, 0);

        // Saturation of the 4-bit counters after 20 flushes
        tick(); settle();
        check_eq("sat_run", s_state, 1);
        branch = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        branch = 1'b0; settle();
        check_eq("sat_flush_small", s_flush_cnt, 15);
        check_eq("sat_flush_wide", flush_cnt, 20);
        check_eq("sat_cycle_small", s_cycle_cnt, 15);
        tick(); tick(); settle();
        check_eq("sat_flush_hold", s_flush_cnt, 15);
        check_eq("sat_stall_small", s_stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
